// File: rtl/bcd_entry.sv
// Decimal keypad front end: collects BCD digits and a sign, converts them
// serially to a two's-complement word and offers it over valid/ready.
module bcd_entry #(
    parameter int unsigned NDIG  = 5,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       digit,
    input  logic             digit_stb,
    input  logic             neg_stb,
    input  logic             clear_stb,
    input  logic             enter_stb,
    output logic [WIDTH-1:0] value,
    output logic             value_vld,
    input  logic             value_rdy,
    output logic [3:0]       dig_0,
    output logic [3:0]       dig_1,
    output logic [3:0]       dig_2,
    output logic [3:0]       dig_3,
    output logic [3:0]       dig_4,
    output logic             sign,
    output logic             err,
    output logic             busy
);

    localparam int unsigned ACC_W  = WIDTH + 1;
    localparam int unsigned CNT_W  = $clog2(NDIG + 1);
    localparam int unsigned IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned ECHO_W = 20;

    // Largest magnitudes representable for each sign
    localparam logic [ACC_W-1:0] NEG_MAX = ACC_W'(1) << (WIDTH - 1);
    localparam logic [ACC_W-1:0] POS_MAX = NEG_MAX - ACC_W'(1);

    typedef enum logic [1:0] {
        ST_ENTRY,
        ST_CONV,
        ST_HOLD
    } state_t;

    state_t                     state_q, state_d;
    logic [NDIG-1:0][3:0]       buf_q, buf_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [ACC_W-1:0]           acc_q, acc_d;
    logic                       chk_q, chk_d;
    logic                       sign_q, sign_d;
    logic                       err_q, err_d;
    logic [WIDTH-1:0]           value_q, value_d;
    logic                       vld_q, vld_d;
    logic                       busy_q, busy_d;
    logic                       in_range;

    // Sign is kept in display polarity (1 = positive)
    assign in_range = sign_q ? (acc_q <= POS_MAX) : (acc_q <= NEG_MAX);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        chk_d   = chk_q;
        sign_d  = sign_q;
        err_d   = err_q;
        value_d = value_q;
        vld_d   = vld_q;

        unique case (state_q)
            ST_ENTRY: begin
                if (clear_stb) begin
                    buf_d  = '0;
                    cnt_d  = '0;
                    sign_d = 1'b1;
                    err_d  = 1'b0;
                end else if (enter_stb) begin
                    err_d   = 1'b0;
                    acc_d   = '0;
                    idx_d   = IDX_W'(NDIG - 1);
                    chk_d   = 1'b0;
                    state_d = ST_CONV;
                end else if (digit_stb) begin
                    if (digit <= 4'd9 && cnt_q != CNT_W'(NDIG)) begin
                        buf_d = {buf_q[NDIG-2:0], digit};
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (neg_stb) begin
                    sign_d = ~sign_q;
                end
            end

            ST_CONV: begin
                if (clear_stb) begin
                    state_d = ST_ENTRY;
                    vld_d   = 1'b0;
                    buf_d   = '0;
                    cnt_d   = '0;
                    sign_d  = 1'b1;
                    err_d   = 1'b0;
                end else if (chk_q) begin
                    // Out-of-range keeps buffer and sign so the user can edit
                    if (in_range) begin
                        value_d = sign_q ? acc_q[WIDTH-1:0]
                                         : (~acc_q[WIDTH-1:0]) + WIDTH'(1);
                        vld_d   = 1'b1;
                        state_d = ST_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_ENTRY;
                    end
                end else begin
                    acc_d = (acc_q << 3) + (acc_q << 1) + ACC_W'(buf_q[idx_q]);
                    if (idx_q == '0) begin
                        chk_d = 1'b1;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end

            ST_HOLD: begin
                if (clear_stb || value_rdy) begin
                    state_d = ST_ENTRY;
                    vld_d   = 1'b0;
                    buf_d   = '0;
                    cnt_d   = '0;
                    sign_d  = 1'b1;
                    if (clear_stb) begin
                        err_d = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_ENTRY;
            end
        endcase

        busy_d = (state_d != ST_ENTRY);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_ENTRY;
            buf_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            chk_q   <= 1'b0;
            sign_q  <= 1'b1;
            err_q   <= 1'b0;
            value_q <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            chk_q   <= chk_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
            value_q <= value_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

    // Echo is a straight view of the buffer registers
    logic [ECHO_W-1:0] echo_w;
    assign echo_w = ECHO_W'(buf_q);

    assign dig_0     = echo_w[3:0];
    assign dig_1     = echo_w[7:4];
    assign dig_2     = echo_w[11:8];
    assign dig_3     = echo_w[15:12];
    assign dig_4     = echo_w[19:16];
    assign sign      = sign_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign value     = value_q;
    assign value_vld = vld_q;

endmodule

// File: tb/tb_bcd_entry.sv
// Bench for bcd_entry: fixed vector table, random sessions against a decimal
// reference model, and hand sequences for abort and asynchronous reset.
module tb_bcd_entry;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  digit;
    logic        digit_stb, neg_stb, clear_stb, enter_stb, value_rdy;
    logic [15:0] value;
    logic        value_vld;
    logic [3:0]  dig_0, dig_1, dig_2, dig_3, dig_4;
    logic        sign, err, busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bcd_entry #(.NDIG(5), .WIDTH(16)) dut (
        .clk(clk), .rst(rst), .digit(digit), .digit_stb(digit_stb),
        .neg_stb(neg_stb), .clear_stb(clear_stb), .enter_stb(enter_stb),
        .value(value), .value_vld(value_vld), .value_rdy(value_rdy),
        .dig_0(dig_0), .dig_1(dig_1), .dig_2(dig_2), .dig_3(dig_3), .dig_4(dig_4),
        .sign(sign), .err(err), .busy(busy)
    );

    function automatic logic [19:0] echo();
        return {dig_4, dig_3, dig_2, dig_1, dig_0};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic pulse(input int which, input logic [3:0] d);
        digit = d;
        case (which)
            0: digit_stb = 1'b1;
            1: neg_stb   = 1'b1;
            2: clear_stb = 1'b1;
            default: enter_stb = 1'b1;
        endcase
        @(posedge clk); #1;
        digit_stb = 1'b0; neg_stb = 1'b0; clear_stb = 1'b0; enter_stb = 1'b0;
    endtask

    // Enter, then count cycles until the block either offers a value or goes idle
    task automatic do_enter(output int cyc);
        pulse(3, 4'd0);
        cyc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (value_vld || !busy) begin
                cyc = c;
                break;
            end
        end
    endtask

    task automatic do_xfer(input int hold_cyc, input logic [15:0] expv);
        for (int w = 0; w < hold_cyc; w++) begin
            @(posedge clk); #1;
        end
        chk("hold_value", value, expv);
        chk("hold_vld", value_vld, 1);
        value_rdy = 1'b1;
        @(posedge clk); #1;
        value_rdy = 1'b0;
        chk("xfer_vld", value_vld, 0);
        chk("xfer_echo", echo(), 0);
        chk("xfer_sign", sign, 1);
        chk("xfer_busy", busy, 0);
        chk("xfer_value_kept", value, expv);
    endtask

    typedef struct {
        int          n;
        int          d[7];
        bit          neg;
        logic [19:0] exp_echo;
        bit          exp_err;
        logic [15:0] exp_val;
    } vec_t;

    vec_t vecs[10];

    // Reference model state
    int          mq[$];
    bit          m_neg;
    logic [15:0] m_last;

    initial begin
        int cyc;
        int mag;
        int k;
        logic [19:0] e;
        logic [15:0] expv;

        vecs[0] = '{5, '{1,2,3,4,5,0,0}, 1'b0, 20'h12345, 1'b0, 16'h3039};
        vecs[1] = '{5, '{3,2,7,6,8,0,0}, 1'b1, 20'h32768, 1'b0, 16'h8000};
        vecs[2] = '{5, '{3,2,7,6,8,0,0}, 1'b0, 20'h32768, 1'b1, 16'h0000};
        vecs[3] = '{6, '{9,9,9,9,9,7,0}, 1'b0, 20'h99999, 1'b1, 16'h0000};
        vecs[4] = '{2, '{4,2,0,0,0,0,0}, 1'b1, 20'h00042, 1'b0, 16'hFFD6};
        vecs[5] = '{0, '{0,0,0,0,0,0,0}, 1'b0, 20'h00000, 1'b0, 16'h0000};
        vecs[6] = '{2, '{12,4,0,0,0,0,0}, 1'b0, 20'h00004, 1'b0, 16'h0004};
        vecs[7] = '{0, '{0,0,0,0,0,0,0}, 1'b1, 20'h00000, 1'b0, 16'h0000};
        vecs[8] = '{5, '{3,2,7,6,7,0,0}, 1'b0, 20'h32767, 1'b0, 16'h7FFF};
        vecs[9] = '{3, '{0,0,7,0,0,0,0}, 1'b1, 20'h00007, 1'b0, 16'hFFF9};

        rst = 1'b0;
        digit = '0; digit_stb = 0; neg_stb = 0; clear_stb = 0; enter_stb = 0; value_rdy = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_value", value, 0);
        chk("rst_vld", value_vld, 0);
        chk("rst_echo", echo(), 0);
        chk("rst_sign", sign, 1);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven vectors; each starts from a cleared buffer
        m_last = 16'h0000;
        foreach (vecs[i]) begin
            pulse(2, 4'd0);
            for (int j = 0; j < vecs[i].n; j++) pulse(0, 4'(vecs[i].d[j]));
            if (vecs[i].neg) pulse(1, 4'd0);
            chk("vec_echo", echo(), vecs[i].exp_echo);
            chk("vec_sign", sign, !vecs[i].neg);
            do_enter(cyc);
            chk("vec_latency", cyc, 6);
            chk("vec_err", err, vecs[i].exp_err);
            if (vecs[i].exp_err) begin
                chk("vec_err_novld", value_vld, 0);
                chk("vec_err_value_kept", value, m_last);
                chk("vec_err_echo_kept", echo(), vecs[i].exp_echo);
                chk("vec_err_sign_kept", sign, !vecs[i].neg);
            end else begin
                chk("vec_value", value, vecs[i].exp_val);
                do_xfer((i == 4) ? 10 : 1, vecs[i].exp_val);
                m_last = vecs[i].exp_val;
            end
        end

        // Random sessions against a decimal model; errors carry the buffer forward
        pulse(2, 4'd0);
        mq.delete();
        m_neg = 1'b0;
        for (int it = 0; it < 60; it++) begin
            if ($urandom_range(0, 4) == 0) begin
                pulse(2, 4'd0);
                mq.delete();
                m_neg = 1'b0;
            end
            k = $urandom_range(0, 7);
            for (int j = 0; j < k; j++) begin
                if ($urandom_range(0, 9) < 8) begin
                    int d = $urandom_range(0, 15);
                    pulse(0, 4'(d));
                    if (d <= 9 && mq.size() < 5) mq.push_back(d);
                end else begin
                    pulse(1, 4'd0);
                    m_neg = !m_neg;
                end
            end
            e = '0;
            for (int i = 0; i < mq.size(); i++) e[i*4 +: 4] = 4'(mq[mq.size()-1-i]);
            chk("rnd_echo", echo(), e);
            chk("rnd_sign", sign, !m_neg);
            mag = 0;
            foreach (mq[i]) mag = mag * 10 + mq[i];
            do_enter(cyc);
            chk("rnd_latency", cyc, 6);
            if (m_neg ? (mag <= 32768) : (mag <= 32767)) begin
                expv = m_neg ? 16'(-mag) : 16'(mag);
                chk("rnd_err0", err, 0);
                chk("rnd_value", value, expv);
                do_xfer($urandom_range(0, 3), expv);
                m_last = expv;
                mq.delete();
                m_neg = 1'b0;
            end else begin
                chk("rnd_err1", err, 1);
                chk("rnd_novld", value_vld, 0);
                chk("rnd_value_kept", value, m_last);
            end
        end

        // Strobes during CONV and HOLD are ignored
        pulse(2, 4'd0);
        pulse(0, 4'd7);
        pulse(3, 4'd0);
        pulse(0, 4'd3);
        pulse(1, 4'd0);
        pulse(3, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("conv_ign_vld", value_vld, 1);
        chk("conv_ign_value", value, 16'h0007);
        pulse(0, 4'd5);
        pulse(1, 4'd0);
        chk("hold_ign_echo", echo(), 20'h00007);
        chk("hold_ign_sign", sign, 1);
        do_xfer(0, 16'h0007);

        // Clear during CONV aborts with no transfer
        pulse(0, 4'd1);
        pulse(0, 4'd2);
        pulse(1, 4'd0);
        pulse(3, 4'd0);
        @(posedge clk); #1;
        chk("abort_busy_pre", busy, 1);
        pulse(2, 4'd0);
        chk("abort_busy", busy, 0);
        chk("abort_echo", echo(), 0);
        chk("abort_sign", sign, 1);
        chk("abort_value_kept", value, 16'h0007);
        repeat (8) @(posedge clk);
        #1;
        chk("abort_no_vld", value_vld, 0);

        // Async reset while holding a value
        pulse(0, 4'd4);
        pulse(0, 4'd2);
        do_enter(cyc);
        chk("hold_latency", cyc, 6);
        chk("hold_value_42", value, 16'h002A);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_vld", value_vld, 0);
        chk("arst_value", value, 0);
        chk("arst_busy", busy, 0);
        chk("arst_echo", echo(), 0);
        chk("arst_sign", sign, 1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("arst_after_vld", value_vld, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
